// File: rtl/sram_scheduler.sv
// Single-port SRAM sequencer arbitrating video reads, boot-loader writes and CPU accesses.
// Optional macro SRAM_WRITE_HOLD_EN adds a data-hold cycle after the write-enable pulse.
module sram_scheduler #(
   parameter int AW = 19
) (
   input  logic          clk,
   input  logic          mrst_n,
   input  logic          loader_en,
   input  logic          video_req,
   input  logic [AW-1:0] video_addr,
   output logic          video_ack,
   output logic [7:0]    video_dout,
   input  logic          loader_req,
   input  logic [AW-1:0] loader_addr,
   input  logic [7:0]    loader_din,
   output logic          loader_ack,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_we_n,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_dout,
   output logic          cpu_ack,
   output logic          cpu_wait_n,
   output logic [AW-1:0] sram_addr,
   output logic [7:0]    sram_dq_out,
   output logic          sram_dq_oe,
   input  logic [7:0]    sram_dq_in,
   output logic          sram_we_n
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_A     = 3'd1;
   localparam logic [2:0] RD_B     = 3'd2;
   localparam logic [2:0] WR_SETUP = 3'd3;
   localparam logic [2:0] WR_PULSE = 3'd4;
   localparam logic [2:0] WR_HOLD  = 3'd5;
`ifdef SRAM_WRITE_HOLD_EN
   localparam logic [2:0] WR_LAST  = WR_HOLD;
`else
   localparam logic [2:0] WR_LAST  = WR_PULSE;
`endif

   localparam logic [1:0] G_VID = 2'd0;
   localparam logic [1:0] G_LDR = 2'd1;
   localparam logic [1:0] G_CPU = 2'd2;

   logic [2:0]    state;
   logic [1:0]    owner;
   logic          served;
   logic          fair;
   logic          v_ok, l_ok, c_ok, sel_vld, sel_we, fin;
   logic [1:0]    sel;
   logic [AW-1:0] sel_addr;
   logic [7:0]    sel_dat;

   // A requester whose ack is showing this cycle sits out this arbitration round.
   always_comb begin
      v_ok     = video_req && !video_ack;
      l_ok     = loader_en && loader_req && !loader_ack;
      c_ok     = !loader_en && cpu_req && !served && !cpu_ack;
      sel_vld  = v_ok || l_ok || c_ok;
      sel      = G_CPU;
      sel_addr = cpu_addr;
      sel_we   = !cpu_we_n;
      sel_dat  = cpu_din;
      if (!(fair && c_ok)) begin
         if (v_ok) begin
            sel      = G_VID;
            sel_addr = video_addr;
            sel_we   = 1'b0;
         end else if (l_ok) begin
            sel      = G_LDR;
            sel_addr = loader_addr;
            sel_we   = 1'b1;
            sel_dat  = loader_din;
         end
      end
      fin = (state == RD_B) || (state == WR_LAST);
   end

   always_ff @(posedge clk) begin
      if (!mrst_n) begin
         state       <= IDLE;
         owner       <= G_VID;
         served      <= 1'b0;
         fair        <= 1'b0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         video_ack   <= 1'b0;
         loader_ack  <= 1'b0;
         cpu_ack     <= 1'b0;
         video_dout  <= 8'h00;
         cpu_dout    <= 8'h00;
      end else begin
         video_ack  <= 1'b0;
         loader_ack <= 1'b0;
         cpu_ack    <= 1'b0;
         // served marks a request already answered; it lives until cpu_req drops
         if (fin && owner == G_CPU) served <= cpu_req;
         else if (!cpu_req)         served <= 1'b0;
         if (fin) begin
            case (owner)
               G_VID:   video_ack  <= 1'b1;
               G_LDR:   loader_ack <= 1'b1;
               default: cpu_ack    <= 1'b1;
            endcase
            if (state == RD_B) begin
               if (owner == G_VID) video_dout <= sram_dq_in;
               else                cpu_dout   <= sram_dq_in;
            end
         end
         case (state)
            IDLE: if (sel_vld) begin
               owner     <= sel;
               sram_addr <= sel_addr;
               if (sel_we) sram_dq_out <= sel_dat;
               state     <= sel_we ? WR_SETUP : RD_A;
               if (sel == G_VID)      fair <= 1'b1;
               else if (sel == G_CPU) fair <= 1'b0;
            end
            RD_A:     state <= RD_B;
            RD_B:     state <= IDLE;
            WR_SETUP: state <= WR_PULSE;
            WR_PULSE: begin
`ifdef SRAM_WRITE_HOLD_EN
               state <= WR_HOLD;
`else
               state <= IDLE;
`endif
            end
            WR_HOLD:  state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   assign sram_dq_oe = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
   assign sram_we_n  = (state != WR_PULSE);
   assign cpu_wait_n = !mrst_n || !(cpu_req && !served);

endmodule

// File: tb/tb_sram_scheduler.sv
// Scoreboard bench for sram_scheduler with a behavioural 512K x 8 SRAM.
// Write latency expectations follow the SRAM_WRITE_HOLD_EN build macro.
module tb_sram_scheduler;
   localparam int AW = 19;
`ifdef SRAM_WRITE_HOLD_EN
   localparam int WLAT = 4, OE_CYC = 3;
`else
   localparam int WLAT = 3, OE_CYC = 2;
`endif

   logic clk = 1'b0, mrst_n = 1'b0, loader_en = 1'b0;
   logic video_req = 1'b0, loader_req = 1'b0, cpu_req = 1'b0, cpu_we_n = 1'b1;
   logic [AW-1:0] video_addr = '0, loader_addr = '0, cpu_addr = '0;
   logic [7:0] loader_din = '0, cpu_din = '0;
   logic video_ack, loader_ack, cpu_ack, cpu_wait_n, sram_dq_oe, sram_we_n;
   logic [7:0] video_dout, cpu_dout, sram_dq_out, sram_dq_in;
   logic [AW-1:0] sram_addr;

   sram_scheduler #(.AW(AW)) dut (
      .clk(clk), .mrst_n(mrst_n), .loader_en(loader_en),
      .video_req(video_req), .video_addr(video_addr), .video_ack(video_ack), .video_dout(video_dout),
      .loader_req(loader_req), .loader_addr(loader_addr), .loader_din(loader_din), .loader_ack(loader_ack),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we_n(cpu_we_n), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:(1<<AW)-1];
   assign sram_dq_in = mem[sram_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_err = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct { int cyc; logic [7:0] d; } exp_t;
   exp_t q_cpu[$];
   exp_t q_vid[$];
   int   q_ldr[$];

   // Monitor: every ack pops its expected response
   always @(negedge clk) begin : mon
      exp_t e;
      int   a;
      if (mrst_n) begin
         if (cpu_ack) begin
            if (q_cpu.size() == 0) chk("cpu_ack_unexpected", 1, 0);
            else begin
               e = q_cpu.pop_front();
               if (e.cyc >= 0) chk("cpu_ack_cycle", cyc, e.cyc);
               chk("cpu_dout", cpu_dout, e.d);
            end
         end
         if (video_ack) begin
            if (q_vid.size() == 0) chk("video_ack_unexpected", 1, 0);
            else begin
               e = q_vid.pop_front();
               if (e.cyc >= 0) chk("video_ack_cycle", cyc, e.cyc);
               chk("video_dout", video_dout, e.d);
            end
         end
         if (loader_ack) begin
            if (q_ldr.size() == 0) chk("loader_ack_unexpected", 1, 0);
            else begin
               a = q_ldr.pop_front();
               chk("loader_mem", mem[a], a & 8'hFF);
            end
         end
      end
   end

   // SRAM write model plus bus-stability watch while the FPGA drives data
   int we_cnt = 0, oe_cnt = 0, stab_bad = 0;
   logic [AW-1:0] wr_a = '0;
   logic [7:0]    wr_d = '0;
   always @(posedge clk) begin
      if (sram_dq_oe) begin
         oe_cnt++;
         if (sram_addr !== wr_a || sram_dq_out !== wr_d) stab_bad++;
      end
      if (!sram_we_n) begin
         we_cnt++;
         mem[sram_addr] = sram_dq_out;
      end
   end

   task automatic wait_cpu_ack(input int lim);
      int t = 0;
      do begin @(negedge clk); t++; end while (!cpu_ack && t < lim);
      if (!cpu_ack) chk("cpu_ack_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int k;
      int t;
      mem[19'h14000] = 8'hA5; mem[19'h0C123] = 8'h00; mem[19'h00100] = 8'h11;
      mem[19'h00200] = 8'h22; mem[19'h0AAAA] = 8'h55;

      // Reset with every request raised
      video_req = 1; loader_req = 1; cpu_req = 1;
      repeat (3) @(negedge clk);
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_oe", sram_dq_oe, 0);
      chk("rst_acks", {video_ack, loader_ack, cpu_ack}, 0);
      chk("rst_wait_n", cpu_wait_n, 1);
      chk("rst_addr", sram_addr, 0);
      chk("rst_douts", {video_dout, cpu_dout}, 0);
      video_req = 0; loader_req = 0; cpu_req = 0;
      @(negedge clk) mrst_n = 1;
      @(negedge clk);

      // CPU read, then hold cpu_req to confirm a single access
      @(negedge clk);
      k = cyc; cpu_addr = 19'h14000; cpu_we_n = 1; cpu_req = 1;
      q_cpu.push_back('{k + 3, 8'hA5});
      #1 chk("rd_wait_n_N", cpu_wait_n, 0);
      @(negedge clk) chk("rd_wait_n_N1", cpu_wait_n, 0);
      @(negedge clk) chk("rd_wait_n_N2", cpu_wait_n, 0);
      @(negedge clk) chk("rd_wait_n_N3", cpu_wait_n, 1);
      repeat (6) @(negedge clk);
      chk("rd_wait_n_held", cpu_wait_n, 1);
      cpu_req = 0;
      @(negedge clk);

      // CPU write; inputs scrambled after grant must not disturb the bus
      we_cnt = 0; oe_cnt = 0; stab_bad = 0; wr_a = 19'h0C123; wr_d = 8'h3C;
      @(negedge clk);
      cpu_addr = 19'h0C123; cpu_din = 8'h3C; cpu_we_n = 0; cpu_req = 1;
      q_cpu.push_back('{cyc + WLAT, 8'hA5});
      @(negedge clk) begin cpu_addr = 19'h7FFFF; cpu_din = 8'hFF; cpu_we_n = 1; end
      wait_cpu_ack(10);
      cpu_req = 0;
      chk("wr_mem", mem[19'h0C123], 8'h3C);
      chk("wr_we_pulses", we_cnt, 1);
      chk("wr_oe_cycles", oe_cnt, OE_CYC);
      chk("wr_bus_stable", stab_bad, 0);
      @(negedge clk);

      // cpu_req dropped right after grant: access still completes
      @(negedge clk);
      cpu_addr = 19'h00200; cpu_we_n = 1; cpu_req = 1;
      q_cpu.push_back('{cyc + 3, 8'h22});
      @(negedge clk) begin cpu_req = 0; cpu_addr = 19'h14000; end
      wait_cpu_ack(6);
      repeat (2) @(negedge clk);

      // Contention: video, cpu, video
      @(negedge clk);
      k = cyc; video_addr = 19'h00100; cpu_addr = 19'h00200; video_req = 1; cpu_req = 1;
      q_vid.push_back('{k + 3, 8'h11});
      q_cpu.push_back('{k + 6, 8'h22});
      q_vid.push_back('{k + 9, 8'h11});
      repeat (9) @(negedge clk);
      video_req = 0; cpu_req = 0;
      repeat (4) @(negedge clk);

      // Boot: loader fills 0..255 while CPU stays blocked; one video read mid-way
      we_cnt = 0; stab_bad = 0;
      loader_en = 1; cpu_req = 1; cpu_addr = 19'h14000;
      for (int i = 0; i < 256; i++) begin
         loader_addr = AW'(i); loader_din = 8'(i); loader_req = 1;
         wr_a = AW'(i); wr_d = 8'(i);
         q_ldr.push_back(i);
         if (i == 100) begin
            video_req = 1;
            q_vid.push_back('{-1, 8'h11});
         end
         t = 0;
         do begin
            @(negedge clk); t++;
            if (video_ack) video_req = 0;
         end while (!loader_ack && t < 20);
         if (!loader_ack) chk("loader_ack_timeout", 0, 1);
         if (i % 32 == 0) chk("boot_wait_n", cpu_wait_n, 0);
      end
      loader_req = 0; cpu_req = 0;
      chk("boot_we_pulses", we_cnt, 256);
      chk("boot_bus_stable", stab_bad, 0);
      chk("boot_mem_ff", mem[19'h000FF], 8'hFF);
      @(negedge clk) loader_en = 0;
      repeat (4) @(negedge clk);

      // Reset asserted while the write pulse is active
      wr_a = 19'h0AAAA; wr_d = 8'h77;
      @(negedge clk);
      cpu_addr = 19'h0AAAA; cpu_din = 8'h77; cpu_we_n = 0; cpu_req = 1;
      @(negedge clk) chk("abort_setup_oe", sram_dq_oe, 1);
      @(negedge clk) chk("abort_pulse_we_n", sram_we_n, 0);
      mrst_n = 0; cpu_req = 0;
      @(negedge clk);
      chk("abort_we_n", sram_we_n, 1);
      chk("abort_oe", sram_dq_oe, 0);
      chk("abort_no_ack", cpu_ack, 0);
      @(negedge clk) begin mrst_n = 1; cpu_we_n = 1; end
      @(negedge clk) chk("abort_release_oe", sram_dq_oe, 0);
      cpu_addr = 19'h14000; cpu_req = 1;
      q_cpu.push_back('{cyc + 3, 8'hA5});
      wait_cpu_ack(6);
      cpu_req = 0;
      repeat (5) @(negedge clk);

      chk("cpu_queue_left", q_cpu.size(), 0);
      chk("video_queue_left", q_vid.size(), 0);
      chk("loader_queue_left", q_ldr.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
